// File: rtl/fifo_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_tx_pkg
// Description : Shared widths and the state type for the FIFO-fed UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_tx_pkg;

   localparam int DATA_W   = 8;
   localparam int FRAMES_W = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick_gen
// Description : Bit-period counter, restarted at frame start, ticking every CLKS_PER_BIT clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

   logic [c_cnt_w-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clear || (r_cnt == c_last)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Tick marks the final cycle of the current bit period.
   assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : UART transmitter popping bytes from a show-ahead FIFO, 8 data bits, optional even parity.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
   import fifo_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [DATA_W-1:0]   fifo_data,
   input  logic                fifo_empty,
   output logic                fifo_read,
   output logic                tx,
   output logic                busy,
   output logic [FRAMES_W-1:0] frames_sent
);

   localparam bit c_parity_en = (PARITY_EN != 0);

   tx_state_t           r_state;
   tx_state_t           w_state_next;
   logic [DATA_W-1:0]   r_shift;
   logic [DATA_W-1:0]   w_shift_next;
   logic [2:0]          r_bit_idx;
   logic [2:0]          w_bit_idx_next;
   logic                r_parity;
   logic                r_tx;
   logic                w_tx_next;
   logic                r_busy;
   logic [FRAMES_W-1:0] r_frames;
   logic                w_pop;
   logic                w_tick;
   logic                w_frame_done;

   // Gated by rst_n so no pop can be seen while reset is held.
   assign w_pop = rst_n && (r_state == IDLE) && enable && !fifo_empty;

   baud_tick_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (w_pop),
      .tick  (w_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_parity  <= 1'b0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
         r_frames  <= '0;
      end else begin
         r_state   <= w_state_next;
         r_shift   <= w_shift_next;
         r_bit_idx <= w_bit_idx_next;
         r_tx      <= w_tx_next;
         r_busy    <= (w_state_next != IDLE);
         if (w_pop) begin
            r_parity <= ^fifo_data;
         end
         if (w_frame_done) begin
            r_frames <= r_frames + 1'b1;
         end
      end
   end

   // tx is registered, so the value loaded here is the level of the coming bit period.
   always_comb begin
      w_state_next   = r_state;
      w_shift_next   = r_shift;
      w_bit_idx_next = r_bit_idx;
      w_tx_next      = r_tx;
      w_frame_done   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pop) begin
               w_state_next   = START;
               w_shift_next   = fifo_data;
               w_bit_idx_next = '0;
               w_tx_next      = 1'b0;
            end
         end
         START: begin
            if (w_tick) begin
               w_state_next = DATA;
               w_tx_next    = r_shift[0];
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_bit_idx == 3'd7) begin
                  w_state_next = c_parity_en ? PARITY : STOP;
                  w_tx_next    = c_parity_en ? r_parity : 1'b1;
               end else begin
                  w_bit_idx_next = r_bit_idx + 1'b1;
                  w_shift_next   = r_shift >> 1;
                  w_tx_next      = r_shift[1];
               end
            end
         end
         PARITY: begin
            if (w_tick) begin
               w_state_next = STOP;
               w_tx_next    = 1'b1;
            end
         end
         STOP: begin
            if (w_tick) begin
               w_state_next = IDLE;
               w_tx_next    = 1'b1;
               w_frame_done = 1'b1;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_tx_next    = 1'b1;
         end
      endcase
   end

   assign fifo_read   = w_pop;
   assign tx          = r_tx;
   assign busy        = r_busy;
   assign frames_sent = r_frames;

endmodule
`default_nettype wire
